traffic_light: RTL and testbench

- Single-intersection traffic-light controller: a Moore FSM cycling RED -> GREEN -> YELLOW -> RED.
- Each phase lasts a parameterised number of timer ticks. Ticks come from an internal clock prescaler.
- Drives a 3-bit one-hot lamp bus directly. Free-running; no inputs other than clock and reset.

---
 rtl/traffic_light.sv | 91 +++++++++
 tb/tb_traffic_light.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light.sv
// Single-intersection traffic-light controller: Moore FSM RED -> GREEN -> YELLOW,
// phase timing in prescaled ticks, registered one-hot lamp outputs.
module traffic_light #(
  parameter int RED_TICKS    = 10,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int TICK_DIV     = 1,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] lights
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;

  typedef enum logic [1:0] {
    ST_RED    = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   last_count;
  logic [PRE_W-1:0]   prescale;
  logic               tick;
  logic               state_legal;
  logic [2:0]         next_lights;

  assign tick = (prescale == PRE_W'(TICK_DIV - 1));

  // Phase bookkeeping: final counter value and successor for the current state.
  always_comb begin
    last_count  = CNT_W'(RED_TICKS - 1);
    next_state  = ST_GREEN;
    next_lights = LAMP_GREEN;
    state_legal = 1'b1;
    case (state)
      ST_RED: begin
        last_count  = CNT_W'(RED_TICKS - 1);
        next_state  = ST_GREEN;
        next_lights = LAMP_GREEN;
      end
      ST_GREEN: begin
        last_count  = CNT_W'(GREEN_TICKS - 1);
        next_state  = ST_YELLOW;
        next_lights = LAMP_YELLOW;
      end
      ST_YELLOW: begin
        last_count  = CNT_W'(YELLOW_TICKS - 1);
        next_state  = ST_RED;
        next_lights = LAMP_RED;
      end
      default: begin
        state_legal = 1'b0;
      end
    endcase
  end

  // Lamps are registered alongside the state so they can only move on a state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RED;
      count    <= '0;
      prescale <= '0;
      lights   <= LAMP_RED;
    end else begin
      prescale <= tick ? '0 : prescale + PRE_W'(1);
      if (!state_legal) begin
        state  <= ST_RED;
        count  <= '0;
        lights <= LAMP_RED;
      end else if (tick) begin
        if (count == last_count) begin
          count  <= '0;
          state  <= next_state;
          lights <= next_lights;
        end else begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_light.sv
// Self-checking bench for traffic_light: three parameterisations on one clock,
// expected lamps from an elapsed-cycle model queued per edge and compared at negedge.
module tb_traffic_light;

  logic       clk;
  logic       rst_a, rst_b, rst_c;
  logic [2:0] lights_a, lights_b, lights_c;

  int n_checks;
  int n_pass;

  logic [2:0] exp_q[$];

  // default timing
  traffic_light u_dflt (
    .clk    (clk),
    .rst    (rst_a),
    .lights (lights_a)
  );

  // slow ticks, one-tick yellow
  traffic_light #(
    .RED_TICKS    (10),
    .GREEN_TICKS  (8),
    .YELLOW_TICKS (1),
    .TICK_DIV     (4),
    .CNT_W        (8)
  ) u_slow (
    .clk    (clk),
    .rst    (rst_b),
    .lights (lights_b)
  );

  // minimal phases
  traffic_light #(
    .RED_TICKS    (1),
    .GREEN_TICKS  (1),
    .YELLOW_TICKS (1),
    .TICK_DIV     (1),
    .CNT_W        (8)
  ) u_ones (
    .clk    (clk),
    .rst    (rst_c),
    .lights (lights_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Lamps after k edges (k = 0 while in reset) from the total elapsed cycles.
  function automatic logic [2:0] model(int k, int r, int g, int y, int d);
    int period;
    int m;
    period = (r + g + y) * d;
    m = k % period;
    if (m < r * d)           return 3'b100;
    else if (m < (r + g) * d) return 3'b001;
    else                     return 3'b010;
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [2:0] want;
    rst_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(3'b100);
      cycle();
      want = exp_q.pop_front();
      n_checks++;
      if (lights_a !== want)
        $display("[TB] FAIL reset_red edge=%0d got=%b want=%b", i, lights_a, want);
      else n_pass++;
    end
    rst_a = 1'b0;
  endtask

  task automatic test_sequence();
    logic [2:0] want;
    for (int k = 1; k <= 31; k++) begin
      exp_q.push_back(model(k, 10, 8, 3, 1));
      cycle();
      want = exp_q.pop_front();
      n_checks++;
      if (lights_a !== want)
        $display("[TB] FAIL sequence edge=%0d got=%b want=%b", k, lights_a, want);
      else n_pass++;
      n_checks++;
      if ($onehot(lights_a) !== 1'b1)
        $display("[TB] FAIL onehot edge=%0d got=%b want=one-hot", k, lights_a);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    logic [2:0] want;
    rst_a = 1'b1;
    cycle();
    cycle();
    rst_a = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      exp_q.push_back(model(k, 10, 8, 3, 1));
      cycle();
      want = exp_q.pop_front();
      n_checks++;
      if (lights_a !== want)
        $display("[TB] FAIL pre_reset edge=%0d got=%b want=%b", k, lights_a, want);
      else n_pass++;
    end
    // edge 13 lands in GREEN; reset must force RED on that very edge
    rst_a = 1'b1;
    exp_q.push_back(3'b100);
    cycle();
    want = exp_q.pop_front();
    n_checks++;
    if (lights_a !== want)
      $display("[TB] FAIL mid_reset got=%b want=%b", lights_a, want);
    else n_pass++;
    rst_a = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      exp_q.push_back(model(k, 10, 8, 3, 1));
      cycle();
      want = exp_q.pop_front();
      n_checks++;
      if (lights_a !== want)
        $display("[TB] FAIL post_reset edge=%0d got=%b want=%b", k, lights_a, want);
      else n_pass++;
    end
  endtask

  task automatic test_slow_tick();
    logic [2:0] want;
    rst_b = 1'b1;
    cycle();
    cycle();
    rst_b = 1'b0;
    // ends mid-GREEN and mid-prescale for the hold test that follows
    for (int k = 1; k <= 122; k++) begin
      exp_q.push_back(model(k, 10, 8, 1, 4));
      cycle();
      want = exp_q.pop_front();
      n_checks++;
      if (lights_b !== want)
        $display("[TB] FAIL slow_tick edge=%0d got=%b want=%b", k, lights_b, want);
      else n_pass++;
    end
  endtask

  task automatic test_all_ones();
    logic [2:0] want;
    rst_c = 1'b1;
    cycle();
    rst_c = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      exp_q.push_back(model(k, 1, 1, 1, 1));
      cycle();
      want = exp_q.pop_front();
      n_checks++;
      if (lights_c !== want)
        $display("[TB] FAIL all_ones edge=%0d got=%b want=%b", k, lights_c, want);
      else n_pass++;
    end
  endtask

  task automatic test_hold_reset();
    logic [2:0] want;
    rst_b = 1'b1;
    for (int i = 0; i < 50; i++) begin
      exp_q.push_back(3'b100);
      cycle();
      want = exp_q.pop_front();
      n_checks++;
      if (lights_b !== want)
        $display("[TB] FAIL hold_reset edge=%0d got=%b want=%b", i, lights_b, want);
      else n_pass++;
    end
    rst_b = 1'b0;
    // a cleared counter and prescaler give a full 40-cycle RED after release
    for (int k = 1; k <= 45; k++) begin
      exp_q.push_back(model(k, 10, 8, 1, 4));
      cycle();
      want = exp_q.pop_front();
      n_checks++;
      if (lights_b !== want)
        $display("[TB] FAIL hold_release edge=%0d got=%b want=%b", k, lights_b, want);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_a    = 1'b1;
    rst_b    = 1'b1;
    rst_c    = 1'b1;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_mid_reset();
    test_slow_tick();
    test_all_ones();
    test_hold_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
